riscv_dmem_arb: RTL and testbench
=================================

Name: riscv_dmem_arb

Overview:
- Two-port arbiter that shares the single-ported data memory (riscv_dmem) between port 0 (core load/store unit) and port 1 (debug/DMA master).
- Per cycle it grants at most one word access.
  - Default policy is round-robin.
  - A requester may lock the memory for a bounded burst.
- Read data is registered and returned one cycle after acceptance.
- Sits between the requesters and riscv_dmem; drives riscv_dmem's write enable, address, write data and byte select, and consumes its read data.

Parameters:
- XLEN, 32, data width; byte-select width is XLEN/8.
- DMEM_ADDR_BIT, 12, data memory byte-address bits; the word-address width AW is DMEM_ADDR_BIT-2.
- LOCK_MAX, 8, maximum consecutive locked grants before forced release; must be at least 2.

Ports:
- i_clk  in  1  clock
- i_rstn  in  1  reset, synchronous, active-low
- i_reqN_valid  in  1  request valid, N=0,1
- o_reqN_ready  out  1  request accepted this cycle
- i_reqN_we  in  1  1 = write, 0 = read
- i_reqN_addr  in  AW  word address
- i_reqN_byte_sel  in  XLEN/8  byte enables (writes only)
- i_reqN_wdata  in  XLEN  write data
- i_reqN_lock  in  1  hold grant after this beat
- o_rspN_valid  out  1  response pulse for an accepted beat
- o_rspN_rdata  out  XLEN  read data
- o_dmem_wr_en  out  1  to riscv_dmem
- o_dmem_addr  out  AW  to riscv_dmem
- o_dmem_data  out  XLEN  to riscv_dmem
- o_dmem_byte_sel  out  XLEN/8  to riscv_dmem
- i_dmem_data  in  XLEN  from riscv_dmem (combinational read)

Behaviour:
- Reset (i_rstn=0 at a rising edge):
  - state=IDLE, rr_ptr=0 (port 0 preferred), lock_cnt=0.
  - o_rspN_valid=0, o_rspN_rdata=0.
  - While reset is asserted: o_reqN_ready=0 and o_dmem_wr_en=0.
  - A beat presented in the reset cycle is not accepted; no response follows reset.
- Handshake:
  - A beat is accepted when valid && ready at the rising edge.
  - ready is combinational from valid and state; valid never depends on ready.
  - A requester holds all request fields stable until accepted.
- Grant, IDLE state:
  - Only one port valid: that port wins.
  - Both valid: the port equal to rr_ptr wins.
  - After an accepted beat from port k: rr_ptr <= ~k.
- Grant, LOCKED state: only the owner may win.
  - The other port sees ready=0 even when the owner's valid is low.
  - Owner's valid low for one cycle: lock releases, state returns to IDLE, and that cycle grants nothing.
- Memory drive:
  - o_dmem_addr, o_dmem_data and o_dmem_byte_sel are combinational muxes of the winner's fields.
  - With no winner they hold the port-0 fields.
  - o_dmem_wr_en = winner_valid && winner_we.
- Read latency:
  - Read accepted in cycle T: i_dmem_data is sampled at the end of T; o_rspK_rdata is updated and o_rspK_valid=1 in T+1.
- Write response:
  - Write accepted in T: o_rspK_valid=1 in T+1; o_rspK_rdata holds its previous value.
  - A write takes effect in memory at the end of T, so a read of the same address accepted in T+1 returns the new data.
- o_rspN_valid is a 1-cycle pulse per accepted beat. Back-to-back accepts give continuous valid.
- LOCK FSM:
  - IDLE -> LOCKED(owner=k), lock_cnt=1, on an accepted beat from k with i_reqk_lock=1.
  - LOCKED -> LOCKED, lock_cnt+1, on an owner beat with lock=1 and lock_cnt < LOCK_MAX-1.
  - LOCKED -> IDLE on:
    - an owner beat with lock=0;
    - an owner beat with lock=1 and lock_cnt = LOCK_MAX-1 (forced release, so LOCK_MAX total grants);
    - owner valid low.
  - On every exit from LOCKED: rr_ptr <= ~owner, so the other port is preferred next.
- Simultaneous events:
  - In IDLE, a lock request from the winner is honoured; the losing port keeps waiting.
  - A lock beat from the losing port has no effect.
- lock_cnt width is clog2(LOCK_MAX) and never wraps.

Decomposition:
- Shared package / riscv_configs.v: XLEN, DMEM_ADDR_BIT, LOCK_MAX default, and state encodings ARB_IDLE=1'b0, ARB_LOCKED=1'b1.
- One natural sub-module: riscv_dmem_arb_rsp, the per-port response register (valid pulse and rdata capture), instantiated twice.
- Grant logic and FSM stay in the top module.

Test Plan:
1. Reset, then port 1 alone writes 0xDEADBEEF to addr 0x10 with byte_sel=4'hF, then reads addr 0x10 -> ready1 in the same cycle as each request; rsp1_valid in T+1 for each beat; rdata1=0xDEADBEEF.
2. Both ports hold valid reads for 4 cycles after reset -> grants 0,1,0,1; each rsp_valid lags its grant by 1.
3. Port 0 writes byte_sel=4'b0010, data 0x0000AB00, to a word preloaded with 0x11223344, then reads it -> rdata0=0x1122AB44.
4. Port 0 issues a locked burst (lock=1 on every beat) with LOCK_MAX=8 while port 1 requests continuously -> 8 consecutive port-0 grants, then port 1 granted next; lock_cnt back to 0.
5. Port 0 is locked and drops valid for one cycle while port 1 is valid -> no grant that cycle; port 1 granted the following cycle.
6. Reset asserted the cycle after a read is accepted -> rsp_valid=0 and rdata=0 after reset; state IDLE; rr_ptr=0.

Source files
------------

// File: rtl/riscv_dmem_arb_pkg.sv
// Shared widths, defaults and FSM encodings for the riscv_dmem two-port arbiter.
package riscv_dmem_arb_pkg;

    localparam int XLEN          = 32;
    localparam int DMEM_ADDR_BIT = 12;
    localparam int AW            = DMEM_ADDR_BIT - 2;
    localparam int BSW           = XLEN / 8;
    localparam int LOCK_MAX_DEF  = 8;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/riscv_dmem_arb_if.sv
// Request/response bundle for both arbiter ports; signal directions named from the arbiter's side.
interface riscv_dmem_arb_if;
    import riscv_dmem_arb_pkg::*;

    logic            i_req0_valid;
    logic            o_req0_ready;
    logic            i_req0_we;
    logic [AW-1:0]   i_req0_addr;
    logic [BSW-1:0]  i_req0_byte_sel;
    logic [XLEN-1:0] i_req0_wdata;
    logic            i_req0_lock;
    logic            o_rsp0_valid;
    logic [XLEN-1:0] o_rsp0_rdata;

    logic            i_req1_valid;
    logic            o_req1_ready;
    logic            i_req1_we;
    logic [AW-1:0]   i_req1_addr;
    logic [BSW-1:0]  i_req1_byte_sel;
    logic [XLEN-1:0] i_req1_wdata;
    logic            i_req1_lock;
    logic            o_rsp1_valid;
    logic [XLEN-1:0] o_rsp1_rdata;

    modport master (
        output i_req0_valid, i_req0_we, i_req0_addr, i_req0_byte_sel, i_req0_wdata, i_req0_lock,
        output i_req1_valid, i_req1_we, i_req1_addr, i_req1_byte_sel, i_req1_wdata, i_req1_lock,
        input  o_req0_ready, o_rsp0_valid, o_rsp0_rdata,
        input  o_req1_ready, o_rsp1_valid, o_rsp1_rdata
    );

    modport slave (
        input  i_req0_valid, i_req0_we, i_req0_addr, i_req0_byte_sel, i_req0_wdata, i_req0_lock,
        input  i_req1_valid, i_req1_we, i_req1_addr, i_req1_byte_sel, i_req1_wdata, i_req1_lock,
        output o_req0_ready, o_rsp0_valid, o_rsp0_rdata,
        output o_req1_ready, o_rsp1_valid, o_rsp1_rdata
    );

endinterface

// File: rtl/riscv_dmem_arb_rsp.sv
// Per-port response register: one-cycle valid pulse per accepted beat, read data captured on reads only.
module riscv_dmem_arb_rsp
    import riscv_dmem_arb_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_rstn,
    input  logic            i_acc,
    input  logic            i_we,
    input  logic [XLEN-1:0] i_rdata,
    output logic            o_valid,
    output logic [XLEN-1:0] o_rdata
);

    logic            valid_d, valid_q;
    logic [XLEN-1:0] rdata_d, rdata_q;

    // Next response: pulse on accept, writes keep the last read data.
    always_comb begin
        valid_d = i_acc;
        rdata_d = rdata_q;
        if (i_acc && !i_we) begin
            rdata_d = i_rdata;
        end else begin
            rdata_d = rdata_q;
        end
    end

    // Response registers.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            valid_q <= 1'b0;
            rdata_q <= {XLEN{1'b0}};
        end else begin
            valid_q <= valid_d;
            rdata_q <= rdata_d;
        end
    end

    assign o_valid = valid_q;
    assign o_rdata = rdata_q;

endmodule

// File: rtl/riscv_dmem_arb.sv
// Round-robin arbiter with bounded lock bursts sharing the single-ported riscv_dmem between two masters.
module riscv_dmem_arb
    import riscv_dmem_arb_pkg::*;
#(
    parameter int LOCK_MAX = LOCK_MAX_DEF
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    riscv_dmem_arb_if.slave  bus,
    output logic             o_dmem_wr_en,
    output logic [AW-1:0]    o_dmem_addr,
    output logic [XLEN-1:0]  o_dmem_data,
    output logic [BSW-1:0]   o_dmem_byte_sel,
    input  logic [XLEN-1:0]  i_dmem_data
);

    localparam int             LCW      = $clog2(LOCK_MAX);
    localparam logic [LCW-1:0] CNT_LAST = LCW'(LOCK_MAX - 1);

    arb_state_e     state_d, state_q;
    logic           owner_d, owner_q;
    logic           rr_ptr_d, rr_ptr_q;
    logic [LCW-1:0] lock_cnt_d, lock_cnt_q;
    logic           gnt0_s, gnt1_s;
    logic           own_valid_s, own_lock_s, win_lock_s;

    // Grant decision; nothing is granted while reset is asserted.
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if (!i_rstn) begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (bus.i_req0_valid && bus.i_req1_valid) begin
                        gnt0_s = ~rr_ptr_q;
                        gnt1_s = rr_ptr_q;
                    end else begin
                        gnt0_s = bus.i_req0_valid;
                        gnt1_s = bus.i_req1_valid;
                    end
                end
                ARB_LOCKED: begin
                    gnt0_s = ~owner_q & bus.i_req0_valid;
                    gnt1_s =  owner_q & bus.i_req1_valid;
                end
                default: begin
                    gnt0_s = 1'b0;
                    gnt1_s = 1'b0;
                end
            endcase
        end
    end

    assign bus.o_req0_ready = gnt0_s;
    assign bus.o_req1_ready = gnt1_s;

    // Memory drive: winner's fields, port 0 fields when idle.
    always_comb begin
        o_dmem_wr_en = (gnt0_s & bus.i_req0_we) | (gnt1_s & bus.i_req1_we);
        if (gnt1_s) begin
            o_dmem_addr     = bus.i_req1_addr;
            o_dmem_data     = bus.i_req1_wdata;
            o_dmem_byte_sel = bus.i_req1_byte_sel;
        end else begin
            o_dmem_addr     = bus.i_req0_addr;
            o_dmem_data     = bus.i_req0_wdata;
            o_dmem_byte_sel = bus.i_req0_byte_sel;
        end
    end

    // Lock FSM, lock counter and round-robin pointer next-state.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        lock_cnt_d  = lock_cnt_q;
        win_lock_s  = gnt1_s ? bus.i_req1_lock : bus.i_req0_lock;
        own_valid_s = owner_q ? bus.i_req1_valid : bus.i_req0_valid;
        own_lock_s  = owner_q ? bus.i_req1_lock  : bus.i_req0_lock;
        case (state_q)
            ARB_IDLE: begin
                if (gnt0_s || gnt1_s) begin
                    rr_ptr_d = ~gnt1_s;
                    if (win_lock_s) begin
                        state_d    = ARB_LOCKED;
                        owner_d    = gnt1_s;
                        lock_cnt_d = LCW'(1);
                    end else begin
                        state_d = ARB_IDLE;
                    end
                end else begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_LOCKED: begin
                // Owner valid low, unlocked beat or the last allowed beat all release.
                if (own_valid_s && own_lock_s && (lock_cnt_q < CNT_LAST)) begin
                    lock_cnt_d = lock_cnt_q + LCW'(1);
                end else begin
                    state_d    = ARB_IDLE;
                    lock_cnt_d = {LCW{1'b0}};
                    rr_ptr_d   = ~owner_q;
                end
            end
            default: begin
                state_d    = ARB_IDLE;
                lock_cnt_d = {LCW{1'b0}};
            end
        endcase
    end

    // Arbiter state registers.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_q    <= ARB_IDLE;
            owner_q    <= 1'b0;
            rr_ptr_q   <= 1'b0;
            lock_cnt_q <= {LCW{1'b0}};
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            lock_cnt_q <= lock_cnt_d;
        end
    end

    riscv_dmem_arb_rsp u_rsp0 (
        .i_clk   (i_clk),
        .i_rstn  (i_rstn),
        .i_acc   (gnt0_s),
        .i_we    (bus.i_req0_we),
        .i_rdata (i_dmem_data),
        .o_valid (bus.o_rsp0_valid),
        .o_rdata (bus.o_rsp0_rdata)
    );

    riscv_dmem_arb_rsp u_rsp1 (
        .i_clk   (i_clk),
        .i_rstn  (i_rstn),
        .i_acc   (gnt1_s),
        .i_we    (bus.i_req1_we),
        .i_rdata (i_dmem_data),
        .o_valid (bus.o_rsp1_valid),
        .o_rdata (bus.o_rsp1_rdata)
    );

endmodule

// File: tb/tb_riscv_dmem_arb.sv
// Directed bench for riscv_dmem_arb with a byte-maskable word memory model standing in for riscv_dmem.
module tb_riscv_dmem_arb;
    import riscv_dmem_arb_pkg::*;

    logic            clk;
    logic            rstn;
    logic            dmem_wr_en;
    logic [AW-1:0]   dmem_addr;
    logic [XLEN-1:0] dmem_wdata;
    logic [BSW-1:0]  dmem_byte_sel;
    logic [XLEN-1:0] dmem_rdata;
    logic [XLEN-1:0] mem [0:(1<<AW)-1];

    int n_total;
    int n_bad;

    riscv_dmem_arb_if bus ();

    riscv_dmem_arb #(.LOCK_MAX(8)) dut (
        .i_clk           (clk),
        .i_rstn          (rstn),
        .bus             (bus.slave),
        .o_dmem_wr_en    (dmem_wr_en),
        .o_dmem_addr     (dmem_addr),
        .o_dmem_data     (dmem_wdata),
        .o_dmem_byte_sel (dmem_byte_sel),
        .i_dmem_data     (dmem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: combinational read, byte-masked write at the clock edge.
    always @(posedge clk) begin
        if (dmem_wr_en) begin
            for (int b = 0; b < BSW; b++) begin
                if (dmem_byte_sel[b]) mem[dmem_addr][8*b +: 8] <= dmem_wdata[8*b +: 8];
            end
        end
    end
    assign dmem_rdata = mem[dmem_addr];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h want=%h @%0t", tag, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic clr();
        bus.i_req0_valid = 1'b0; bus.i_req0_we = 1'b0; bus.i_req0_addr = '0;
        bus.i_req0_byte_sel = 4'h0; bus.i_req0_wdata = 32'h0; bus.i_req0_lock = 1'b0;
        bus.i_req1_valid = 1'b0; bus.i_req1_we = 1'b0; bus.i_req1_addr = '0;
        bus.i_req1_byte_sel = 4'h0; bus.i_req1_wdata = 32'h0; bus.i_req1_lock = 1'b0;
    endtask

    task automatic do_reset();
        cyc();
        rstn = 1'b0;
        clr();
        cyc();
        rstn = 1'b1;
    endtask

    initial begin
        int exp_g [4];
        exp_g = '{0, 1, 0, 1};
        n_total = 0;
        n_bad   = 0;
        for (int i = 0; i < (1<<AW); i++) mem[i] = 32'h0;

        // Reset with a write beat presented: must not be accepted
        clr();
        rstn = 1'b0;
        bus.i_req0_valid = 1'b1; bus.i_req0_we = 1'b1; bus.i_req0_byte_sel = 4'hF;
        cyc();
        smp();
        chk("rst_ready0", bus.o_req0_ready, 32'd0);
        chk("rst_wr_en", dmem_wr_en, 32'd0);
        cyc();
        rstn = 1'b1;
        clr();
        smp();
        chk("rst_rsp0_valid", bus.o_rsp0_valid, 32'd0);
        chk("rst_rsp0_rdata", bus.o_rsp0_rdata, 32'd0);
        chk("rst_rsp1_valid", bus.o_rsp1_valid, 32'd0);

        // Test 1: port 1 alone writes then reads 0x10
        cyc();
        bus.i_req1_valid = 1'b1; bus.i_req1_we = 1'b1; bus.i_req1_addr = 10'h010;
        bus.i_req1_wdata = 32'hDEADBEEF; bus.i_req1_byte_sel = 4'hF;
        smp();
        chk("t1_wr_ready1", bus.o_req1_ready, 32'd1);
        chk("t1_wr_ready0", bus.o_req0_ready, 32'd0);
        chk("t1_wr_en", dmem_wr_en, 32'd1);
        chk("t1_addr", dmem_addr, 32'h010);
        chk("t1_wdata", dmem_wdata, 32'hDEADBEEF);
        cyc();
        bus.i_req1_we = 1'b0;
        smp();
        chk("t1_rd_ready1", bus.o_req1_ready, 32'd1);
        chk("t1_wr_rsp_valid", bus.o_rsp1_valid, 32'd1);
        chk("t1_wr_rsp_rdata", bus.o_rsp1_rdata, 32'd0);
        chk("t1_rd_wr_en", dmem_wr_en, 32'd0);
        cyc();
        clr();
        smp();
        chk("t1_rd_rsp_valid", bus.o_rsp1_valid, 32'd1);
        chk("t1_rd_rdata", bus.o_rsp1_rdata, 32'hDEADBEEF);
        cyc();
        smp();
        chk("t1_rsp_pulse_end", bus.o_rsp1_valid, 32'd0);

        // Test 2: both ports read continuously, round-robin 0,1,0,1
        do_reset();
        bus.i_req0_valid = 1'b1; bus.i_req0_addr = 10'h010;
        bus.i_req1_valid = 1'b1; bus.i_req1_addr = 10'h010;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) cyc();
            smp();
            chk("t2_ready0", bus.o_req0_ready, (exp_g[i] == 0) ? 32'd1 : 32'd0);
            chk("t2_ready1", bus.o_req1_ready, (exp_g[i] == 1) ? 32'd1 : 32'd0);
            if (i > 0) begin
                chk("t2_rsp0_valid", bus.o_rsp0_valid, (exp_g[i-1] == 0) ? 32'd1 : 32'd0);
                chk("t2_rsp1_valid", bus.o_rsp1_valid, (exp_g[i-1] == 1) ? 32'd1 : 32'd0);
            end
        end
        cyc();
        clr();
        smp();
        chk("t2_last_rsp1_valid", bus.o_rsp1_valid, 32'd1);
        chk("t2_last_rsp0_valid", bus.o_rsp0_valid, 32'd0);
        chk("t2_rsp1_rdata", bus.o_rsp1_rdata, 32'hDEADBEEF);
        chk("t2_rsp0_rdata", bus.o_rsp0_rdata, 32'hDEADBEEF);

        // Test 3: partial byte write merges into preloaded word
        cyc();
        bus.i_req0_valid = 1'b1; bus.i_req0_we = 1'b1; bus.i_req0_addr = 10'h020;
        bus.i_req0_wdata = 32'h11223344; bus.i_req0_byte_sel = 4'hF;
        smp();
        chk("t3_preload_ready0", bus.o_req0_ready, 32'd1);
        cyc();
        bus.i_req0_wdata = 32'h0000AB00; bus.i_req0_byte_sel = 4'b0010;
        smp();
        chk("t3_wr_en", dmem_wr_en, 32'd1);
        chk("t3_byte_sel", dmem_byte_sel, 32'h2);
        cyc();
        bus.i_req0_we = 1'b0;
        smp();
        chk("t3_rd_ready0", bus.o_req0_ready, 32'd1);
        cyc();
        clr();
        smp();
        chk("t3_rsp0_valid", bus.o_rsp0_valid, 32'd1);
        chk("t3_rsp0_rdata", bus.o_rsp0_rdata, 32'h1122AB44);

        // Test 4: port 0 locked burst against a continuously requesting port 1
        do_reset();
        bus.i_req0_valid = 1'b1; bus.i_req0_lock = 1'b1; bus.i_req0_addr = 10'h020;
        bus.i_req1_valid = 1'b1; bus.i_req1_addr = 10'h010;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) cyc();
            smp();
            chk("t4_burst_ready0", bus.o_req0_ready, 32'd1);
            chk("t4_burst_ready1", bus.o_req1_ready, 32'd0);
            chk("t4_lock_cnt", dut.lock_cnt_q, i);
        end
        cyc();
        smp();
        chk("t4_release_ready0", bus.o_req0_ready, 32'd0);
        chk("t4_release_ready1", bus.o_req1_ready, 32'd1);
        chk("t4_cnt_cleared", dut.lock_cnt_q, 32'd0);
        chk("t4_state_idle", dut.state_q, 32'd0);
        cyc();
        clr();

        // Test 5: locked owner drops valid for one cycle
        do_reset();
        bus.i_req0_valid = 1'b1; bus.i_req0_lock = 1'b1;
        bus.i_req1_valid = 1'b1;
        smp();
        chk("t5_lock_ready0", bus.o_req0_ready, 32'd1);
        cyc();
        bus.i_req0_valid = 1'b0;
        smp();
        chk("t5_gap_ready0", bus.o_req0_ready, 32'd0);
        chk("t5_gap_ready1", bus.o_req1_ready, 32'd0);
        chk("t5_gap_rsp0_valid", bus.o_rsp0_valid, 32'd1);
        cyc();
        smp();
        chk("t5_after_ready1", bus.o_req1_ready, 32'd1);
        chk("t5_after_rsp0_valid", bus.o_rsp0_valid, 32'd0);
        chk("t5_after_rsp1_valid", bus.o_rsp1_valid, 32'd0);
        cyc();
        clr();

        // Test 6: reset right after a read is accepted
        bus.i_req0_valid = 1'b1; bus.i_req0_addr = 10'h020;
        smp();
        chk("t6_ready0", bus.o_req0_ready, 32'd1);
        cyc();
        rstn = 1'b0;
        smp();
        chk("t6_rst_ready0", bus.o_req0_ready, 32'd0);
        chk("t6_rsp0_valid_pre", bus.o_rsp0_valid, 32'd1);
        chk("t6_rsp0_rdata_pre", bus.o_rsp0_rdata, 32'h1122AB44);
        cyc();
        rstn = 1'b1;
        clr();
        smp();
        chk("t6_rsp0_valid_post", bus.o_rsp0_valid, 32'd0);
        chk("t6_rsp0_rdata_post", bus.o_rsp0_rdata, 32'd0);
        chk("t6_state_post", dut.state_q, 32'd0);
        chk("t6_rr_post", dut.rr_ptr_q, 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
